// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding, instruction size, the prefetch buffer entry layout and a
// small address helper.
package fetch_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Every instruction is one 32-bit word
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // One prefetch buffer entry: instruction word in the upper half,
    // its byte PC in the lower half (64 bits total)
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] byte_addr);
        return byte_addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous prefetch FIFO with extra-MSB pointers. The pointers carry
// one bit more than the index so full and empty can be told apart
// without a separate counter. Pointers reset asynchronously so the
// buffer reads empty the instant reset is asserted; storage is not
// reset because dout is only meaningful while the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] PTR_ONE  = {{IW{1'b0}}, 1'b1};
    localparam logic [IW:0] PTR_ZERO = {(IW+1){1'b0}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IW:0]      wr_ptr_q;
    logic [IW:0]      wr_ptr_d;
    logic [IW:0]      rd_ptr_q;
    logic [IW:0]      rd_ptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Equal index with differing wrap bit means every slot is occupied
    assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
                   (wr_ptr_q[IW] != rd_ptr_q[IW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // A pop frees the head slot, so a push on a full FIFO is legal then
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    assign dout = mem_q[rd_ptr_q[IW-1:0]];

    // Pointer next-state: flush wins over any traffic in the same cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers, cleared asynchronously so contents vanish at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; written only on an accepted, non-flushed push
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_q[wr_ptr_q[IW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller. Walks a byte PC through an external,
// combinationally-read instruction memory and queues {word, pc} pairs
// in a small prefetch FIFO for decode. Redirects flush the queue and
// retarget the PC; running off the end of memory parks the block in
// DONE until an in-range redirect arrives.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          ADDR_W     = 6,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [31:0]       inst_pc,
    output logic              done
);

    // Bits above the memory's byte range; any set bit means out of range
    localparam int HI_W = 32 - ADDR_W - 2;

    logic [1:0]   state_q;
    logic [1:0]   state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;

    logic         fifo_full_s;
    logic         fifo_empty_s;
    logic         push_s;
    logic         pop_s;
    logic [31:0]  redirect_tgt_s;
    logic         pc_in_range_s;
    logic         tgt_in_range_s;
    fetch_entry_t din_s;
    fetch_entry_t dout_s;

    assign redirect_tgt_s = align_word(redirect_pc);
    assign pc_in_range_s  = (pc_q[31:ADDR_W+2] == {HI_W{1'b0}});
    assign tgt_in_range_s = (redirect_tgt_s[31:ADDR_W+2] == {HI_W{1'b0}});

    // Decode consumes the head whenever both sides agree
    assign pop_s = ~fifo_empty_s & inst_ready;

    // Fetch only while running, not redirecting, still inside memory and
    // with room (a same-cycle pop counts as room)
    assign push_s = (state_q == ST_FETCH) & run & ~redirect_valid &
                    pc_in_range_s & (~fifo_full_s | pop_s);

    assign din_s.inst = mem_data;
    assign din_s.pc   = pc_q;

    assign mem_addr   = pc_q[ADDR_W+1:2];
    assign inst_valid = ~fifo_empty_s;
    assign inst_out   = dout_s.inst;
    assign inst_pc    = dout_s.pc;
    assign done       = (state_q == ST_DONE);

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .din   (din_s),
        .dout  (dout_s)
    );

    // FSM next-state: redirects dominate, then end-of-memory, then run
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            if (!tgt_in_range_s) begin
                state_d = ST_DONE;
            end else if (run) begin
                state_d = ST_FETCH;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_FETCH: begin
                    if (!pc_in_range_s) begin
                        state_d = ST_DONE;
                    end else if (run) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // PC next-state: redirect target, else advance one word per push
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_tgt_s;
        end else if (push_s) begin
            pc_d = pc_q + INSTR_BYTES;
        end else begin
            pc_d = pc_q;
        end
    end

    // State and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6: instruction-memory word-address width (64 words).
REQ-002 Parameter FIFO_DEPTH, default 2: prefetch buffer entries, power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: byte PC loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 run  input  1  1 = fetching permitted; 0 = hold the PC and stop pushing.
REQ-007 redirect_valid  input  1  branch/jump taken; one-cycle strobe.
REQ-008 redirect_pc  input  32  byte target of the redirect.
REQ-009 mem_addr  output  ADDR_W  word address to instruction memory; equals pc[ADDR_W+1:2].
REQ-010 mem_data  input  32  combinational read data from instruction memory.
REQ-011 inst_valid  output  1  FIFO head is valid.
REQ-012 inst_ready  input  1  decode accepts the head.
REQ-013 inst_out  output  32  head instruction word.
REQ-014 inst_pc  output  32  byte PC of the head instruction.
REQ-015 done  output  1  fetch PC has run past the end of memory.

Function
REQ-016 The block SHALL implement the states IDLE, FETCH and DONE, with IDLE as the reset state.
REQ-017 IDLE->FETCH SHALL occur when run=1; FETCH->IDLE SHALL occur when run=0 (the FIFO is kept); IDLE and FETCH SHALL go to DONE when the PC reaches 4*2^ADDR_W or more.
REQ-018 DONE SHALL be left only by a redirect with an in-range target, to FETCH if run=1, otherwise to IDLE.
REQ-019 A push SHALL occur in FETCH with no redirect when the FIFO is not full, or is full with a pop in the same cycle; a push SHALL store {mem_data, pc} and set pc to pc+4.
REQ-020 A pop SHALL occur when inst_valid and inst_ready are both 1.
REQ-021 Latency: a word fetched in cycle N SHALL appear on inst_out in cycle N+1 when the FIFO was empty.
REQ-022 With inst_ready held at 1, throughput SHALL be one instruction per cycle.
REQ-023 A simultaneous push and pop on a full FIFO SHALL leave the occupancy unchanged.
REQ-024 A redirect SHALL empty the FIFO, SHALL set pc to {redirect_pc[31:2], 2'b00}, and SHALL block any push in that cycle.
REQ-025 A pop in the same cycle as a redirect SHALL count as consumed; no entry older than the redirect SHALL be presented afterwards.
REQ-026 A redirect target of 4*2^ADDR_W or more SHALL send the block directly to DONE with the FIFO empty.
REQ-027 done SHALL be 1 only in DONE, and SHALL NOT clear FIFO entries that were pushed before DONE was entered.
REQ-028 The FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
REQ-029 FIFO full SHALL be detected by equal index bits with differing MSBs; FIFO empty SHALL be detected by equal pointers.

Reset
REQ-030 While rst=1, the block SHALL hold: state=IDLE, pc=RESET_PC, FIFO empty, inst_valid=0, done=0, mem_addr=RESET_PC[ADDR_W+1:2].
REQ-031 rst asserted in mid-operation SHALL discard all FIFO contents immediately, without waiting for a clock edge.
REQ-032 FIFO data storage SHALL NOT need a reset; inst_out and inst_pc SHALL be don't-care while inst_valid=0.

Structure
REQ-033 The state encoding (IDLE/FETCH/DONE) and the constant INSTR_BYTES=4 SHALL be placed in the shared package fetch_pkg.
REQ-034 The prefetch buffer SHALL be the sub-module sync_fifo, with parameters WIDTH=64 and DEPTH=FIFO_DEPTH and ports push, pop, flush, full, empty, din and dout.
REQ-035 The instruction memory SHALL NOT be instantiated inside this block; it SHALL connect through mem_addr and mem_data only.

Verification
REQ-036 Reset and stream: release rst, run=1, inst_ready=1 -> inst_pc sequence 0,4,8,...; first inst_valid one cycle after leaving IDLE; inst_out equal to the memory word at each inst_pc.
REQ-037 Backpressure: inst_ready=0 for 5 cycles -> FIFO holds 2 entries, pc stops at head+8; on inst_ready=1 the pcs continue in order with no gap or duplicate.
REQ-038 Redirect with pop: FIFO full, redirect_pc=32'h0000_0012 with inst_ready=1 -> next inst_pc=32'h10, stale entries never shown.
REQ-039 End of memory: run from pc 32'hF8 -> words at F8 and FC delivered, then done=1 and no further pushes; redirect to 32'h20 -> done=0, fetch resumes at 32'h20.
REQ-040 Out-of-range redirect and async reset: redirect_pc=32'h400 -> DONE in 1 cycle with FIFO empty; rst asserted between edges mid-stream -> inst_valid=0 immediately and pc=RESET_PC.
